// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register, and halts on
// an out-of-window or misaligned fetch address until reset.
//
//   state  | meaning
//   RUN    | fetching normally; PC advances, redirects and stalls honoured
//   HALTED | sticky fault; PC frozen, IF/ID fed bubbles until reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'hBFC00000,
  parameter int          WINDOW_BITS = 12,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchFault,
  output logic [31:0] FaultPC,
  output logic [31:0] InstrCount
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        in_window;
  logic        misalign;
  logic        fault;
  logic [31:0] pc_nxt;
  logic        ifid_bubble;
  logic        ifid_hold;
  logic        ifid_load;
  logic [31:0] fault_pc_nxt;

  assign in_window = (PCF[31:WINDOW_BITS] == RESET_PC[31:WINDOW_BITS]);
  assign misalign  = PCSrcE && (PCTargetE[1:0] != 2'b00);
  assign fault     = (state == RUN) && (!in_window || misalign);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (fault) state_nxt = HALTED;
  end

  // A faulting edge freezes the PC so FaultPC and PCF stay coherent.
  always_comb begin
    pc_nxt       = PCF;
    ifid_bubble  = 1'b0;
    ifid_hold    = 1'b0;
    ifid_load    = 1'b0;
    fault_pc_nxt = misalign ? PCTargetE : PCF;
    if (state == RUN && !fault) begin
      if (PCSrcE)       pc_nxt = PCTargetE;
      else if (!StallF) pc_nxt = PCF + 32'd4;
    end
    if (FlushD || (state == RUN && PCSrcE)) ifid_bubble = 1'b1;
    else if (StallD)                        ifid_hold   = 1'b1;
    else if (state == RUN && in_window)     ifid_load   = 1'b1;
    else                                    ifid_bubble = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PCF        <= RESET_PC;
      InstrD     <= NOP_INSTR;
      PCD        <= 32'd0;
      PCPlus4D   <= 32'd0;
      ValidD     <= 1'b0;
      FetchFault <= 1'b0;
      FaultPC    <= 32'd0;
      InstrCount <= 32'd0;
    end else begin
      PCF <= pc_nxt;
      if (ifid_load) begin
        InstrD     <= InstrF;
        PCD        <= PCF;
        PCPlus4D   <= PCF + 32'd4;
        ValidD     <= 1'b1;
        InstrCount <= InstrCount + 32'd1;
      end else if (ifid_bubble) begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
      if (fault) begin
        FetchFault <= 1'b1;
        FaultPC    <= fault_pc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// compared against a rule-level reference model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] WIN_SIZE = 32'h00001000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic [31:0] InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FaultPC, InstrCount;
  logic        ValidD, FetchFault;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_faultpc, m_count;
  logic        m_valid, m_fault, m_halted;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchFault(FetchFault), .FaultPC(FaultPC), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  function automatic logic in_win(input logic [31:0] pc);
    return (pc >= RESET_PC) && (pc - RESET_PC < WIN_SIZE);
  endfunction

  // Memory contents: word k of the window holds 00100093+k; outside reads zero.
  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    if (in_win(pc)) return 32'h00100093 + ((pc - RESET_PC) >> 2);
    return 32'd0;
  endfunction

  always_comb InstrF = instr_at(PCF);

  task automatic model_update();
    logic oow, mis, bubble;
    if (rst) begin
      m_pc = RESET_PC; m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
      m_fault = 0; m_faultpc = 0; m_count = 0; m_halted = 0;
      return;
    end
    oow = !in_win(m_pc);
    mis = PCSrcE && (PCTargetE % 4 != 0);
    bubble = FlushD || (!m_halted && PCSrcE);
    if (!bubble && StallD) begin
      // hold IF/ID
    end else if (!bubble && !m_halted && !oow) begin
      m_instr = instr_at(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 4;
      m_valid = 1; m_count = m_count + 1;
    end else begin
      m_instr = NOP; m_valid = 0;
    end
    if (!m_halted) begin
      if (mis || oow) begin
        m_halted = 1; m_fault = 1;
        m_faultpc = mis ? PCTargetE : m_pc;
      end else if (PCSrcE) m_pc = PCTargetE;
      else if (!StallF)    m_pc = m_pc + 4;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tg);
    rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tg;
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 1, 1, 32'h12345678);
    tick();
    total++; if (PCF !== RESET_PC) $display("FAIL reset_pcf got %h exp %h", PCF, RESET_PC); else passed++;
    total++; if (InstrD !== NOP) $display("FAIL reset_instrd got %h exp %h", InstrD, NOP); else passed++;
    total++; if (PCD !== 0 || PCPlus4D !== 0) $display("FAIL reset_pcd got %h/%h exp 0/0", PCD, PCPlus4D); else passed++;
    total++; if (ValidD !== 0 || FetchFault !== 0) $display("FAIL reset_flags got %b/%b exp 0/0", ValidD, FetchFault); else passed++;
    total++; if (FaultPC !== 0 || InstrCount !== 0) $display("FAIL reset_cnt got %h/%h exp 0/0", FaultPC, InstrCount); else passed++;
  endtask

  task automatic test_free_run();
    set_in(1, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (PCF !== RESET_PC + 4 * k) $display("FAIL free_pcf got %h exp %h", PCF, RESET_PC + 4 * k); else passed++;
      total++; if (InstrD !== 32'h00100093 + k - 1 || ValidD !== 1)
        $display("FAIL free_instrd got %h v%b exp %h v1", InstrD, ValidD, 32'h00100093 + k - 1); else passed++;
    end
    total++; if (InstrCount !== 3) $display("FAIL free_count got %0d exp 3", InstrCount); else passed++;
    total++; if (PCPlus4D !== RESET_PC + 12) $display("FAIL free_pc4d got %h exp %h", PCPlus4D, RESET_PC + 12); else passed++;
  endtask

  task automatic test_stall();
    set_in(1, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); tick(); tick();
    set_in(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (PCF !== RESET_PC + 8) $display("FAIL stall_pcf got %h exp %h", PCF, RESET_PC + 8); else passed++;
      total++; if (InstrD !== 32'h00100094 || InstrCount !== 2)
        $display("FAIL stall_hold got %h/%0d exp 00100094/2", InstrD, InstrCount); else passed++;
    end
    set_in(0, 0, 0, 0, 0, 0); tick();
    total++; if (PCF !== RESET_PC + 12) $display("FAIL stall_resume got %h exp %h", PCF, RESET_PC + 12); else passed++;
  endtask

  task automatic test_redirect_stall();
    set_in(0, 1, 0, 0, 1, RESET_PC + 32'h100); tick();
    total++; if (PCF !== RESET_PC + 32'h100) $display("FAIL redir_pcf got %h exp %h", PCF, RESET_PC + 32'h100); else passed++;
    total++; if (InstrD !== NOP || ValidD !== 0) $display("FAIL redir_bubble got %h v%b exp %h v0", InstrD, ValidD, NOP); else passed++;
    set_in(0, 0, 0, 0, 0, 0); tick();
    total++; if (PCD !== RESET_PC + 32'h100 || ValidD !== 1)
      $display("FAIL redir_target got %h v%b exp %h v1", PCD, ValidD, RESET_PC + 32'h100); else passed++;
  endtask

  task automatic test_flush_stall();
    logic [31:0] pcd_before;
    pcd_before = PCD;
    set_in(0, 0, 1, 1, 0, 0); tick();
    total++; if (InstrD !== NOP || ValidD !== 0) $display("FAIL flush_bubble got %h v%b exp %h v0", InstrD, ValidD, NOP); else passed++;
    total++; if (PCD !== pcd_before) $display("FAIL flush_pcd got %h exp %h", PCD, pcd_before); else passed++;
  endtask

  task automatic test_window_overflow();
    set_in(0, 0, 0, 0, 1, RESET_PC + 32'hFFC); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    total++; if (PCD !== RESET_PC + 32'hFFC || ValidD !== 1 || InstrD !== instr_at(RESET_PC + 32'hFFC))
      $display("FAIL ovf_last got %h v%b exp %h v1", PCD, ValidD, RESET_PC + 32'hFFC); else passed++;
    total++; if (PCF !== RESET_PC + WIN_SIZE) $display("FAIL ovf_pcf got %h exp %h", PCF, RESET_PC + WIN_SIZE); else passed++;
    tick();
    total++; if (FetchFault !== 1 || FaultPC !== RESET_PC + WIN_SIZE)
      $display("FAIL ovf_fault got %b/%h exp 1/%h", FetchFault, FaultPC, RESET_PC + WIN_SIZE); else passed++;
    total++; if (ValidD !== 0) $display("FAIL ovf_valid got %b exp 0", ValidD); else passed++;
    set_in(0, 0, 0, 0, 1, RESET_PC); tick();
    total++; if (PCF !== RESET_PC + WIN_SIZE || FetchFault !== 1)
      $display("FAIL halt_ignore got %h/%b exp %h/1", PCF, FetchFault, RESET_PC + WIN_SIZE); else passed++;
  endtask

  task automatic test_misaligned();
    set_in(1, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, RESET_PC + 32'h102); tick();
    total++; if (FetchFault !== 1 || FaultPC !== RESET_PC + 32'h102)
      $display("FAIL mis_fault got %b/%h exp 1/%h", FetchFault, FaultPC, RESET_PC + 32'h102); else passed++;
    set_in(1, 0, 0, 0, 0, 0); tick();
    total++; if (PCF !== RESET_PC || FetchFault !== 0 || InstrCount !== 0)
      $display("FAIL mis_reset got %h/%b/%0d exp %h/0/0", PCF, FetchFault, InstrCount, RESET_PC); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] tg;
    set_in(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 400; i++) begin
      tg = RESET_PC + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 15) == 0) tg = tg + $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) tg = RESET_PC + WIN_SIZE - 4 * $urandom_range(1, 3);
      set_in($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, tg);
      tick();
      total++;
      if (PCF !== m_pc || InstrD !== m_instr || PCD !== m_pcd || PCPlus4D !== m_pc4d ||
          ValidD !== m_valid || FetchFault !== m_fault || FaultPC !== m_faultpc || InstrCount !== m_count)
        $display("FAIL rand_%0d got pc=%h i=%h pcd=%h p4=%h v=%b f=%b fpc=%h n=%0d exp pc=%h i=%h pcd=%h p4=%h v=%b f=%b fpc=%h n=%0d",
                 i, PCF, InstrD, PCD, PCPlus4D, ValidD, FetchFault, FaultPC, InstrCount,
                 m_pc, m_instr, m_pcd, m_pc4d, m_valid, m_fault, m_faultpc, m_count);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_flush_stall();
    test_window_overflow();
    test_misaligned();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V pipeline, directly upstream of the instruction memory.
- Owns the program counter and drives PCF to the memory; captures the returned InstrF into the IF/ID pipeline register.
- Handles hazard-unit stalls and flushes, and EX-stage branch/jump redirects.
- Detects out-of-window or misaligned fetch addresses and halts in a sticky fault state.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- WINDOW_BITS, 12, log2 of the instruction window size in bytes; the window is PC[31:WINDOW_BITS] == RESET_PC[31:WINDOW_BITS].
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- StallF  input  1  hold PCF (from hazard unit).
- StallD  input  1  hold the IF/ID register.
- FlushD  input  1  load a bubble into the IF/ID register.
- PCSrcE  input  1  taken branch/jump in EX; redirect to PCTargetE.
- PCTargetE  input  32  redirect target.
- InstrF  input  32  instruction word returned combinationally by the instruction memory for PCF.
- PCF  output  32  current fetch address, to the instruction memory.
- InstrD  output  32  IF/ID instruction.
- PCD  output  32  IF/ID PC.
- PCPlus4D  output  32  IF/ID PC+4.
- ValidD  output  1  1 when InstrD is a real fetched instruction.
- FetchFault  output  1  sticky fault flag.
- FaultPC  output  32  offending address, captured at fault entry.
- InstrCount  output  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - PCF=RESET_PC.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - FetchFault=0, FaultPC=0, InstrCount=0.
  - State=RUN.
- Reset overrides every other input, including mid-stall and HALTED.
- State machine has two states, RUN and HALTED.
- RUN to HALTED occurs at the edge where either condition holds:
  - (a) PCF is outside the window;
  - (b) PCSrcE=1 and PCTargetE[1:0]!=0.
- On that edge, FetchFault is set to 1.
- FaultPC captures PCF for case (a) and PCTargetE for case (b).
- If both (a) and (b) hold at the same edge, (b) wins.
- HALTED is exited only by reset.
- Next-PC rule in RUN, in priority order:
  1. PCSrcE=1 → PCF=PCTargetE. Redirect wins over StallF.
  2. StallF=1 → PCF holds.
  3. Otherwise → PCF=PCF+4, 32-bit wrap with no carry out.
- In HALTED, PCF holds and PCSrcE is ignored.
- Sequential overflow: PCF=RESET_PC+2^WINDOW_BITS-4 is fetched normally. The next PCF is out-of-window, which faults on the following edge. The out-of-window InstrF (zero) never reaches ValidD=1.
- IF/ID register update rule, in priority order:
  1. FlushD=1, or PCSrcE=1 while in RUN → bubble. Bubble means InstrD=NOP_INSTR, ValidD=0, PCD and PCPlus4D hold.
  2. StallD=1 → all IF/ID fields hold.
  3. RUN and PCF in-window → InstrD=InstrF, PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
  4. Otherwise (HALTED, or faulting edge) → bubble.
- FlushD together with StallD: flush wins.
- InstrCount increments by 1 on each edge that loads ValidD=1. It wraps at 2^32.
- Latency: an instruction at PCF appears on InstrD one cycle later. A redirect asserted at edge N makes PCF=PCTargetE after edge N, and that instruction appears on InstrD after edge N+1.
- Misaligned sequential PCs cannot occur, because reset and all accepted targets are word-aligned.

Test Plan:
- Reset then 4 free-run cycles, InstrF driven as 32'h00100093+k → PCF steps BFC00000, BFC00004, BFC00008, BFC0000C. InstrD lags one cycle with ValidD=1. InstrCount=3 after the 4th edge.
- StallF=StallD=1 for 2 cycles at PCF=BFC00008 → PCF, InstrD and InstrCount all hold. Resume gives PCF=BFC0000C.
- PCSrcE=1, PCTargetE=BFC00100, with StallF=1 on the same edge → PCF=BFC00100 and InstrD=00000013 with ValidD=0. Next edge: PCD=BFC00100, ValidD=1.
- FlushD=1 with StallD=1 → InstrD=00000013, ValidD=0, PCD unchanged.
- Redirect to BFC00FFC, then free-run → BFC00FFC is fetched validly, then PCF=BFC01000. Next edge: FetchFault=1, FaultPC=BFC01000. PCF stays BFC01000 and PCSrcE is ignored.
- PCSrcE=1, PCTargetE=BFC00102 → FetchFault=1, FaultPC=BFC00102. Then rst=1 for one edge → PCF=BFC00000, FetchFault=0, InstrCount=0.
